// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// Accepts one request at a time, waits WAIT_CYCLES, then registers a response
// and holds it until the core takes it.
// Optional feature: define DMEM_RESP_PIPE_EN to let RESP accept the next
// request on the same edge that completes the current response.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,  // power of two, 4..65536
   parameter int WAIT_CYCLES = 2     // 0..15 extra wait states
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] mem [DEPTH_WORDS];

   logic             accept;
   logic             load_rsp;
   logic             acc_we;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [3:0]       acc_be;
   logic             acc_err;
   logic [IDX_W-1:0] acc_idx;

   // The access being resolved: the captured request while waiting, otherwise
   // the live request (only used when it is accepted straight into RESP).
   assign acc_we    = (state_q == ST_WAIT) ? we_q    : req_we;
   assign acc_addr  = (state_q == ST_WAIT) ? addr_q  : req_addr;
   assign acc_wdata = (state_q == ST_WAIT) ? wdata_q : req_wdata;
   assign acc_be    = (state_q == ST_WAIT) ? be_q    : req_be;
   assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
   assign acc_idx   = acc_addr[IDX_W+1:2];

   // Errors and writes return zero data; reads return the whole word.
   assign rdata_d = (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
   assign err_d   = acc_err;

   // Next-state, handshake and response-load decode.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      load_rsp  = 1'b0;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d  = ST_RESP;
               load_rsp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
`ifdef DMEM_RESP_PIPE_EN
            req_ready = rsp_ready;
`endif
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      accept = req_valid && req_ready;
      if (accept) begin
         if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
         end else begin
            state_d  = ST_RESP;
            load_rsp = 1'b1;
         end
      end
   end

   // FSM state, wait counter and registered response.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load_rsp) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end
      end
   end

   // Request capture; contents are only consumed in WAIT, so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   // Byte-masked write commit on the RESP-entry edge; a coincident reset wins.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately left out of reset; contents survive rst_n.
      if (rst_n && load_rsp && acc_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// u_dut runs WAIT_CYCLES=2 for the functional tests; u_dut0 runs WAIT_CYCLES=0
// for the back-to-back response spacing test.
module tb_dmem_responder;

   localparam int WAIT = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_be;

   logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
   logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
   logic [3:0]  z_req_be;

   int   n_checks = 0;
   int   n_bad    = 0;
   exp_t sb[$];
   exp_t sb0[$];
   exp_t z_e;
   logic [31:0] model_mem [256];
   logic z_win = 1'b0;
   logic z_prev = 1'b0;
   int   z_rises = 0;
   int   z_highs = 0;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
      .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
      .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
      .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Present a request on u_dut until it is accepted, then scramble the inputs.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic ok);
      int n;
      n = 0;
      ok = 1'b0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      while (!ok && n < 20) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk); #1;
         n++;
      end
      req_valid = 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      check("accept", 32'(ok), 32'd1);
   endtask

   // One full transaction: push expectation, check latency, hold, handshake.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold);
      exp_t       e;
      logic       ok;
      logic       err;
      logic [7:0] idx;
      int         k;
      issue(we, addr, wdata, be, ok);
      if (!ok) return;
      idx = addr[9:2];
      err = (addr[1:0] != 2'b00) || (addr >= 32'h400);
      e.err = err;
      if (we) begin
         e.rdata = 32'd0;
         if (!err) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
         end
      end else begin
         e.rdata = err ? 32'd0 : model_mem[idx];
      end
      sb.push_back(e);
      // The accept edge leaves k=0; rsp_valid is first set WAIT edges later,
      // so the core first samples it on edge WAIT+1 after acceptance.
      k = 0;
      while (!rsp_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check("latency", 32'(k), 32'(WAIT));
      if (!rsp_valid) begin
         e = sb.pop_front();
         return;
      end
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", rsp_rdata, sb[0].rdata);
         check("hold_err", 32'(rsp_err), 32'(sb[0].err));
         check("hold_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      e = sb.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("done_valid", 32'(rsp_valid), 32'd0);
      check("done_req_ready", 32'(req_ready), 32'd1);
   endtask

   // Accept a full-word write, then reset rst_after edges after the accept edge.
   task automatic abandon_write(input logic [31:0] addr, input logic [31:0] wdata, input int rst_after);
      logic ok;
      logic seen;
      seen = 1'b0;
      issue(1'b1, addr, wdata, 4'hF, ok);
      repeat (rst_after - 1) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("abandon_no_rsp", 32'(seen), 32'd0);
      @(posedge clk); #1;
   endtask

   // Present a request on u_dut0 (rsp_ready tied high); valid stays up afterwards.
   task automatic drive0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata);
      exp_t e;
      logic ok;
      int   n;
      ok = 1'b0;
      n = 0;
      z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata; z_req_be = 4'hF;
      while (!ok && n < 20) begin
         @(negedge clk);
         ok = z_req_ready;
         @(posedge clk); #1;
         n++;
      end
      check("z_accept", 32'(ok), 32'd1);
      if (ok) begin
         e.rdata = exp_rdata;
         e.err   = 1'b0;
         sb0.push_back(e);
      end
   endtask

   // u_dut0 response monitor and rsp_valid spacing counters.
   always @(negedge clk) begin
      if (z_rsp_valid && z_rsp_ready) begin
         if (sb0.size() == 0) begin
            check("z_unexpected_rsp", 32'(z_rsp_valid), 32'd0);
         end else begin
            z_e = sb0.pop_front();
            check("z_rsp_rdata", z_rsp_rdata, z_e.rdata);
            check("z_rsp_err", 32'(z_rsp_err), 32'(z_e.err));
         end
      end
      if (z_win) begin
         if (z_rsp_valid) z_highs++;
         if (z_rsp_valid && !z_prev) z_rises++;
      end
      z_prev = z_rsp_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
      z_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_req_ready", 32'(req_ready), 32'd1);

      // Basic write then read, held for five cycles.
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      do_txn(1'b0, 32'h10, 32'h0, 4'hF, 5);
      // Byte-lane merge.
      do_txn(1'b1, 32'h30, 32'h11223344, 4'hF, 0);
      do_txn(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1);
      do_txn(1'b0, 32'h30, 32'h0, 4'h0, 0);
      // Out-of-range and misaligned accesses must not touch aliased words.
      do_txn(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 0);
      do_txn(1'b0, 32'h400, 32'h0, 4'hF, 0);
      do_txn(1'b0, 32'h13, 32'h0, 4'hF, 0);
      do_txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
      do_txn(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 2);
      do_txn(1'b0, 32'h0, 32'h0, 4'hF, 0);
      do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
      // Empty byte mask leaves storage alone.
      do_txn(1'b1, 32'h10, 32'h0BADF00D, 4'h0, 0);
      do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
      // Reset while waiting abandons the write.
      do_txn(1'b1, 32'h20, 32'h0, 4'hF, 0);
      do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
      abandon_write(32'h20, 32'hCAFEF00D, 1);
      do_txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
      // Reset on the RESP-entry edge also wins.
      do_txn(1'b1, 32'h24, 32'h0, 4'hF, 0);
      do_txn(1'b0, 32'h30, 32'h0, 4'hF, 0);
      abandon_write(32'h24, 32'h12345678, 2);
      do_txn(1'b0, 32'h24, 32'h0, 4'hF, 0);

      // Random traffic over the first 16 words, with some illegal addresses.
      for (int w = 0; w < 16; w++) do_txn(1'b1, 32'(w) << 2, $urandom, 4'hF, 0);
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a;
         int          sel;
         a = 32'($urandom_range(0, 15)) << 2;
         sel = $urandom_range(0, 7);
         if (sel == 0) a = a | 32'($urandom_range(1, 3));
         else if (sel == 1) a = a + 32'h400;
         do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end
      check("sb_empty", 32'(sb.size()), 32'd0);

      // Zero-wait back-to-back reads on u_dut0.
      drive0(1'b1, 32'h0, 32'h0A0A0A0A, 32'h0);
      z_req_valid = 1'b0;
      drive0(1'b1, 32'h4, 32'h0B0B0B0B, 32'h0);
      z_req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      z_rises = 0;
      z_highs = 0;
      z_win = 1'b1;
      drive0(1'b0, 32'h0, 32'h0, 32'h0A0A0A0A);
      drive0(1'b0, 32'h4, 32'h0, 32'h0B0B0B0B);
      z_req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      z_win = 1'b0;
`ifdef DMEM_RESP_PIPE_EN
      check("z_valid_rises", 32'(z_rises), 32'd1);
`else
      check("z_valid_rises", 32'(z_rises), 32'd2);
`endif
      check("z_valid_highs", 32'(z_highs), 32'd2);
      check("z_sb_empty", 32'(sb0.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words; it SHALL be a power of two from 4 to 65536.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving extra access wait states; it SHALL be an integer from 0 to 15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  the core presents a request.
REQ-006 req_ready  output  1  the responder can accept a request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  the response is valid.
REQ-012 rsp_ready  input  1  the core accepts the response.
REQ-013 rsp_rdata  output  32  read data.
REQ-014 rsp_err  output  1  the access was misaligned or out of range.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP. At most one transaction SHALL be outstanding.
REQ-016 A request SHALL be accepted on any rising edge where req_valid=1 and req_ready=1. On acceptance, we, addr, wdata and be SHALL be captured. Inputs outside an accepting edge SHALL be ignored.
REQ-017 In IDLE, req_ready SHALL be 1. On acceptance, the next state SHALL be WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES-1; it SHALL then go to RESP.
REQ-019 rsp_valid SHALL rise exactly WAIT_CYCLES+1 rising edges after the accepting edge.
REQ-020 The response SHALL be held until rsp_ready=1.
REQ-021 On the edge that enters RESP, the response SHALL be registered as follows:
- A write SHALL commit to storage on this edge.
- A read SHALL register the full word into rsp_rdata, ignoring be.
REQ-022 rsp_rdata, rsp_err and rsp_valid SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-023 The storage word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-024 An access with addr[1:0]!=0 or addr>=4*DEPTH_WORDS SHALL have the following response:
- rsp_err=1 and rsp_rdata=0.
- No storage write.
- The same latency as a legal access.
REQ-025 A write with be=4'b0000 SHALL leave storage unchanged, give rsp_err=0 and give rsp_rdata=0.
REQ-026 rsp_rdata SHALL be 0 for every write response.
REQ-027 In RESP, when rsp_ready=1, the next state SHALL be IDLE, unless REQ-033 applies.
REQ-028 In WAIT, req_ready SHALL be 0. In RESP, req_ready SHALL also be 0 unless DMEM_RESP_PIPE_EN is defined.

Reset
REQ-029 While rst_n=0 at a rising edge, the following SHALL hold on the next cycle:
- state=IDLE and the counter is 0.
- req_ready=1 (asserted from the first cycle after reset).
- rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-030 Storage contents SHALL NOT be reset or cleared.
REQ-031 A reset in WAIT SHALL abandon the transaction. The pending write SHALL NOT commit and no response SHALL be issued.
REQ-032 A reset coinciding with the RESP-entry edge SHALL win: no write commit and rsp_valid=0.

Configuration
REQ-033 With macro DMEM_RESP_PIPE_EN defined, the following SHALL hold in RESP:
- req_ready SHALL equal rsp_ready.
- An edge with rsp_ready=1 and req_valid=1 SHALL complete the old response and accept a new request on that same edge, with the next state per REQ-017.
- With WAIT_CYCLES=0, rsp_valid SHALL then stay 1 carrying the new response.
REQ-034 Without DMEM_RESP_PIPE_EN, RESP SHALL always return to IDLE, giving a minimum of one bubble cycle between responses; the behaviour SHALL be otherwise identical.

Verification
REQ-035 WAIT_CYCLES=2, write addr=0x10, wdata=0xDEADBEEF, be=4'hF, then read addr=0x10 -> write rsp_valid 3 edges after accept with err=0; read rsp_rdata=0xDEADBEEF.
REQ-036 Over a word of 0x11223344, write wdata=0xAABBCCDD, be=4'b0101, then read -> rsp_rdata=0x11BB33DD.
REQ-037 DEPTH_WORDS=256, read addr=0x400 and read addr=0x13 -> each gives rsp_err=1 and rsp_rdata=0, with no storage change.
REQ-038 Response issued, rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout.
REQ-039 rst_n=0 one cycle after accepting a write of 0xCAFEF00D to addr=0x20, where the word holds 0x0 -> no rsp_valid; a later read of 0x20 returns 0x00000000.
REQ-040 WAIT_CYCLES=0, two back-to-back reads with rsp_ready=1 -> with DMEM_RESP_PIPE_EN, rsp_valid stays high for 2 consecutive cycles; without it, a one-cycle rsp_valid=0 gap appears.
